// File: rtl/scr1_dmem_vec_serializer_pkg.sv
// Shared memory-interface types and vector-serializer constants (package scr1_memif).
// LANE and SCR1_DMEM_AWIDTH fall back to 4 / 32 when the build does not set them.
`ifndef LANE
`define LANE 4
`endif
`ifndef SCR1_DMEM_AWIDTH
`define SCR1_DMEM_AWIDTH 32
`endif

package scr1_memif;

   typedef enum logic {
      SCR1_MEM_CMD_RD = 1'b0,
      SCR1_MEM_CMD_WR = 1'b1
   } type_scr1_mem_cmd_e;

   typedef enum logic [1:0] {
      SCR1_MEM_WIDTH_BYTE   = 2'b00,
      SCR1_MEM_WIDTH_HWORD  = 2'b01,
      SCR1_MEM_WIDTH_WORD   = 2'b10,
      SCR1_MEM_WIDTH_VECTOR = 2'b11
   } type_scr1_mem_width_e;

   typedef enum logic [1:0] {
      SCR1_MEM_RESP_IDLE   = 2'b00,
      SCR1_MEM_RESP_RDY_OK = 2'b01,
      SCR1_MEM_RESP_RDY_ER = 2'b10
   } type_scr1_mem_resp_e;

   typedef logic [`LANE-1:0][31:0] type_vector;

   localparam int SCR1_VSER_LANE      = `LANE;
   localparam int SCR1_VSER_CNT_W     = $clog2(`LANE);
   localparam int SCR1_VSER_BEAT_OFFS = 4;

endpackage

// File: rtl/scr1_vser_lane_buf.sv
// Lane gather buffer: LANE x 32 register with synchronous clear, indexed write and
// full-vector read.
module scr1_vser_lane_buf
   import scr1_memif::*;
(
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       clr,
   input  logic                       we,
   input  logic [SCR1_VSER_CNT_W-1:0] idx,
   input  logic [31:0]                wdata,
   output type_vector                 rdata
);

   type_vector buf_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         buf_q <= '0;
      end else if (clr) begin
         buf_q <= '0;
      end else if (we) begin
         buf_q[idx] <= wdata;
      end
   end

   assign rdata = buf_q;

endmodule

// File: rtl/scr1_dmem_vec_serializer.sv
// Splits LSU vector accesses into sequential 32-bit beats and gathers the load lanes.
// Build option: SCR1_VSER_ERR_ABORT_EN ends a vector at its first RDY_ER beat.
//
// state     | meaning
// IDLE      | ready for an LSU request (req_ack high)
// BEAT_REQ  | beat request on the memory side, waiting for ack
// BEAT_WAIT | beat accepted, waiting for its response
// DONE      | one-cycle LSU response with gathered data
module scr1_dmem_vec_serializer
   import scr1_memif::*;
#(
   parameter int LANE   = SCR1_VSER_LANE,
   parameter int AWIDTH = `SCR1_DMEM_AWIDTH
)(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 lsu2dmem_req,
   input  type_scr1_mem_cmd_e   lsu2dmem_cmd,
   input  type_scr1_mem_width_e lsu2dmem_width,
   input  logic [AWIDTH-1:0]    lsu2dmem_addr,
   input  type_vector           lsu2dmem_wdata,
   output logic                 dmem2lsu_req_ack,
   output type_vector           dmem2lsu_rdata,
   output type_scr1_mem_resp_e  dmem2lsu_resp,
   output logic                 vser2mem_req,
   output type_scr1_mem_cmd_e   vser2mem_cmd,
   output type_scr1_mem_width_e vser2mem_width,
   output logic [AWIDTH-1:0]    vser2mem_addr,
   output logic [31:0]          vser2mem_wdata,
   input  logic                 mem2vser_req_ack,
   input  logic [31:0]          mem2vser_rdata,
   input  type_scr1_mem_resp_e  mem2vser_resp
);

   localparam int CW = SCR1_VSER_CNT_W;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'b00,
      ST_BEAT_REQ  = 2'b01,
      ST_BEAT_WAIT = 2'b10,
      ST_DONE      = 2'b11
   } vser_state_e;

   vser_state_e          state_q, state_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [CW-1:0]        last_q;
   logic                 err_q, err_d;
   type_scr1_mem_cmd_e   cmd_q;
   type_scr1_mem_width_e width_q;
   logic [AWIDTH-1:0]    addr_q;
   type_vector           wdata_q;
   logic                 accept;
   logic                 buf_clr;
   logic                 buf_we;

   assign accept = (state_q == ST_IDLE) && lsu2dmem_req;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end

   // Request context is held for the whole burst so beat outputs stay stable under stall.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cmd_q   <= SCR1_MEM_CMD_RD;
         width_q <= SCR1_MEM_WIDTH_BYTE;
         addr_q  <= '0;
         wdata_q <= '0;
         last_q  <= '0;
      end else if (accept) begin
         cmd_q   <= lsu2dmem_cmd;
         width_q <= lsu2dmem_width;
         addr_q  <= lsu2dmem_addr;
         wdata_q <= lsu2dmem_wdata;
         last_q  <= (lsu2dmem_width == SCR1_MEM_WIDTH_VECTOR) ? CW'(LANE - 1) : '0;
      end
   end

   always_comb begin
      state_d          = state_q;
      cnt_d            = cnt_q;
      err_d            = err_q;
      buf_clr          = 1'b0;
      buf_we           = 1'b0;
      dmem2lsu_req_ack = 1'b0;
      dmem2lsu_resp    = SCR1_MEM_RESP_IDLE;
      vser2mem_req     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            dmem2lsu_req_ack = 1'b1;
            if (lsu2dmem_req) begin
               state_d = ST_BEAT_REQ;
               cnt_d   = '0;
               err_d   = 1'b0;
               buf_clr = 1'b1;
            end
         end
         ST_BEAT_REQ: begin
            vser2mem_req = 1'b1;
            if (mem2vser_req_ack) begin
               state_d = ST_BEAT_WAIT;
            end
         end
         ST_BEAT_WAIT: begin
            if (mem2vser_resp == SCR1_MEM_RESP_RDY_OK) begin
               buf_we = (cmd_q == SCR1_MEM_CMD_RD);
            end
            if (mem2vser_resp == SCR1_MEM_RESP_RDY_ER) begin
               err_d = 1'b1;
            end
            if (mem2vser_resp != SCR1_MEM_RESP_IDLE) begin
               if (cnt_q == last_q) begin
                  state_d = ST_DONE;
               end else begin
                  cnt_d   = cnt_q + 1'b1;
                  state_d = ST_BEAT_REQ;
               end
`ifdef SCR1_VSER_ERR_ABORT_EN
               if (mem2vser_resp == SCR1_MEM_RESP_RDY_ER) begin
                  cnt_d   = cnt_q;
                  state_d = ST_DONE;
               end
`endif
            end
         end
         ST_DONE: begin
            dmem2lsu_resp = err_q ? SCR1_MEM_RESP_RDY_ER : SCR1_MEM_RESP_RDY_OK;
            state_d       = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign vser2mem_cmd   = cmd_q;
   assign vser2mem_width = (width_q == SCR1_MEM_WIDTH_VECTOR) ? SCR1_MEM_WIDTH_WORD : width_q;
   assign vser2mem_addr  = (width_q == SCR1_MEM_WIDTH_VECTOR)
                           ? addr_q + AWIDTH'(cnt_q) * AWIDTH'(SCR1_VSER_BEAT_OFFS)
                           : addr_q;
   assign vser2mem_wdata = wdata_q[cnt_q];

   scr1_vser_lane_buf i_lane_buf (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (buf_clr),
      .we    (buf_we),
      .idx   (cnt_q),
      .wdata (mem2vser_rdata),
      .rdata (dmem2lsu_rdata)
   );

`ifndef SYNTHESIS
   // Responses outside BEAT_WAIT are dropped by the FSM; flag them so the source can be found.
   spurious_resp_a: assert property (@(posedge clk) disable iff (!rst_n)
      (state_q != ST_BEAT_WAIT) |-> (mem2vser_resp == SCR1_MEM_RESP_IDLE))
      else $warning("vser: memory response outside BEAT_WAIT ignored");
`endif

endmodule
